// File: rtl/os_xor_accum_pkg.sv
// Shared slice-word types and defaults for consumers of the OS_XOR2 slice cells.
package os_pkg;

    localparam int OS_SLICE_W   = 7;
    localparam int OS_FRAME_LEN = 8;

    typedef logic [OS_SLICE_W-1:0] os_slice_t;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } os_acc_state_e;

endpackage

// File: rtl/os_xor_accum_if.sv
// Beat input and syndrome output handshakes of the XOR accumulator.
interface os_xor_accum_if #(
    parameter int W = os_pkg::OS_SLICE_W
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_y;
    logic         in_flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_syn;
    logic         out_nz;

    modport master (
        output in_valid,
        output in_y,
        output in_flush,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_syn,
        input  out_nz
    );

    modport slave (
        input  in_valid,
        input  in_y,
        input  in_flush,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_syn,
        output out_nz
    );

endinterface

// File: rtl/os_xor_accum_out_reg.sv
// Syndrome holding register: {nz, syn} with a valid/ready output side.
module os_out_reg
    import os_pkg::*;
#(
    parameter int W = OS_SLICE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic         o_fire,
    output logic [W-1:0] o_syn,
    output logic         o_nz
);

    os_acc_state_e r_state;
    os_acc_state_e w_state_nxt;
    logic [W:0]    r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A load while handing off keeps HOLD and replaces the word.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ACC: begin
                if (i_load) w_state_nxt = HOLD;
            end
            HOLD: begin
                if (i_ready && !i_load) w_state_nxt = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= {|i_data, i_data};
        end
    end

    always_comb begin
        o_valid = (r_state == HOLD);
        o_fire  = o_valid && i_ready;
        o_syn   = r_data[W-1:0];
        o_nz    = r_data[W];
    end

endmodule

// File: rtl/os_xor_accum.sv
// Frame XOR accumulator behind the OS_XOR2 slices; define
// OS_XOR_ACCUM_ERRCNT_EN to add the saturating nonzero-syndrome counter.
module os_xor_accum
    import os_pkg::*;
#(
    parameter int W         = OS_SLICE_W,
    parameter int FRAME_LEN = OS_FRAME_LEN,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    os_xor_accum_if.slave    bus,
    output logic [CNT_W-1:0] frame_cnt
`ifdef OS_XOR_ACCUM_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int BW = 16;
    localparam logic [BW-1:0] LAST = BW'(FRAME_LEN - 1);

    logic [BW-1:0]    r_beat;
    logic [W-1:0]     r_acc;
    logic [CNT_W-1:0] r_frame_cnt;

    logic         w_in_ready;
    logic         w_accept;
    logic         w_last;
    logic         w_load;
    logic [W-1:0] w_next;
    logic         w_out_valid;
    logic         w_fire;
    logic [W-1:0] w_syn;
    logic         w_nz;

    assign w_in_ready = !bus.in_flush && (!w_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_beat == LAST);
    assign w_load     = w_accept && w_last;
    // First beat seeds the accumulator so no explicit clear is needed.
    assign w_next     = (r_beat == '0) ? bus.in_y : (r_acc ^ bus.in_y);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_acc  <= '0;
        end else if (bus.in_flush) begin
            r_beat <= '0;
            r_acc  <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_beat <= '0;
                r_acc  <= '0;
            end else begin
                r_beat <= r_beat + 1'b1;
                r_acc  <= w_next;
            end
        end
    end

    os_out_reg #(
        .W (W)
    ) u_out_reg (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_data  (w_next),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_fire  (w_fire),
        .o_syn   (w_syn),
        .o_nz    (w_nz)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_fire) begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

`ifdef OS_XOR_ACCUM_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_fire && w_nz && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_syn   = w_syn;
    assign bus.out_nz    = w_nz;
    assign frame_cnt     = r_frame_cnt;

endmodule
